// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t      : arbiter sequencing states
//   DMEM_DEPTH   : number of 32-bit words in the data memory
//   DMEM_DATA_W  : data width of the memory
//   DMEM_ADDR_W  : address width of the memory (Dir)
//   P0 / P1      : requester port identifiers
package dmem_arb_pkg;

    localparam int DMEM_DEPTH  = 128;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 32;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector.
//   req[1:0]   : request lines, bit n = port n
//   last_grant : port that completed the previous access
//   gnt_valid  : at least one request is pending
//   gnt_id     : chosen port (only meaningful when gnt_valid)
// On a tie the port that did not win last time is chosen.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = P0;
        case (req)
            2'b01:   gnt_id = P0;
            2'b10:   gnt_id = P1;
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = P0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Each granted access runs IDLE -> ACCESS -> DONE: the request is latched at
// the grant edge, the memory strobe is a registered single-cycle level in
// ACCESS, and the requester sees a one-cycle ack (with err/rdata) in DONE.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rN_req/we/addr/wdata        : port N request (held until rN_ack)
//   rN_ack/err/rdata            : port N completion pulse, range error, read data
//   MemWrite/MemRead/Din/Dir    : registered memory controls
//   Dout                        : combinational memory read data
//   busy                        : an access is in progress
//   owner                       : port currently or last granted
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [DATA_W-1:0] Din,
    output logic [ADDR_W-1:0] Dir,
    input  logic [DATA_W-1:0] Dout,
    output logic              busy,
    output logic              owner
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t state_reg, state_next;

    logic last_grant_reg;
    logic id_reg;
    logic we_reg;
    logic err_reg;

    logic gnt_valid;
    logic gnt_id;

    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

    logic [DATA_W-1:0] rdata_capture;

    logic [1:0]        ack_vec;
    logic [1:0]        err_vec;
    logic [DATA_W-1:0] rdata_vec [2];

    assign req_vec      = {r1_req, r0_req};
    assign we_vec       = {r1_we, r0_we};
    assign addr_vec[0]  = r0_addr;
    assign addr_vec[1]  = r1_addr;
    assign wdata_vec[0] = r0_wdata;
    assign wdata_vec[1] = r1_wdata;

    rr_pick2 u_pick (
        .req        (req_vec),
        .last_grant (last_grant_reg),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        sel_we       = we_vec[gnt_id];
        sel_addr     = addr_vec[gnt_id];
        sel_wdata    = wdata_vec[gnt_id];
        sel_in_range = (sel_addr < DEPTH_A);
    end

    // Writes and out-of-range accesses return zero read data.
    assign rdata_capture = (we_reg || err_reg) ? '0 : Dout;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (gnt_valid) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grant latch and memory drive. Strobes are only raised at the grant
    // edge, so they are high for exactly the ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= P1;
            id_reg         <= P0;
            we_reg         <= 1'b0;
            err_reg        <= 1'b0;
            MemWrite       <= 1'b0;
            MemRead        <= 1'b0;
            Din            <= '0;
            Dir            <= '0;
            owner          <= P0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt_valid) begin
                        id_reg   <= gnt_id;
                        we_reg   <= sel_we;
                        err_reg  <= ~sel_in_range;
                        Dir      <= sel_addr;
                        Din      <= sel_wdata;
                        MemWrite <= sel_we & sel_in_range;
                        MemRead  <= ~sel_we & sel_in_range;
                        owner    <= gnt_id;
                    end
                end
                ACCESS: begin
                    MemWrite <= 1'b0;
                    MemRead  <= 1'b0;
                end
                DONE: begin
                    last_grant_reg <= id_reg;
                end
                default: begin
                    MemWrite <= 1'b0;
                    MemRead  <= 1'b0;
                end
            endcase
        end
    end

    // Per-port completion registers: loaded at the end of ACCESS for the
    // granted port, so ack/err are high only during DONE.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              ack_reg;
        logic              err_q_reg;
        logic [DATA_W-1:0] rdata_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ack_reg   <= 1'b0;
                err_q_reg <= 1'b0;
                rdata_reg <= '0;
            end else if (state_reg == ACCESS && id_reg == 1'(gi)) begin
                ack_reg   <= 1'b1;
                err_q_reg <= err_reg;
                rdata_reg <= rdata_capture;
            end else begin
                ack_reg   <= 1'b0;
                err_q_reg <= 1'b0;
            end
        end

        assign ack_vec[gi]   = ack_reg;
        assign err_vec[gi]   = err_q_reg;
        assign rdata_vec[gi] = rdata_reg;
    end

    assign r0_ack   = ack_vec[0];
    assign r0_err   = err_vec[0];
    assign r0_rdata = rdata_vec[0];
    assign r1_ack   = ack_vec[1];
    assign r1_err   = err_vec[1];
    assign r1_rdata = rdata_vec[1];

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a memory model on the Mem* side, directed
// scenarios, then randomized two-port traffic. A transaction-level reference
// (grant rule, 3-cycle access timeline, reference memory) predicts every
// output each cycle.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_q = 2'b00;
    logic [1:0]  we_q = 2'b00;
    logic [31:0] addr_q  [2];
    logic [31:0] wdata_q [2];

    logic        r0_ack, r0_err, r1_ack, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic        MemWrite, MemRead, busy, owner;
    logic [31:0] Din, Dir, Dout;

    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r0_req   (req_q[0]),
        .r0_we    (we_q[0]),
        .r0_addr  (addr_q[0]),
        .r0_wdata (wdata_q[0]),
        .r0_ack   (r0_ack),
        .r0_err   (r0_err),
        .r0_rdata (r0_rdata),
        .r1_req   (req_q[1]),
        .r1_we    (we_q[1]),
        .r1_addr  (addr_q[1]),
        .r1_wdata (wdata_q[1]),
        .r1_ack   (r1_ack),
        .r1_err   (r1_err),
        .r1_rdata (r1_rdata),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .Din      (Din),
        .Dir      (Dir),
        .Dout     (Dout),
        .busy     (busy),
        .owner    (owner)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'd67;
        if (i == 1) return 32'd101;
        return 32'h1000_0000 ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    // Memory attached to the DUT: combinational read, write on strobe.
    logic [31:0] mem [128];
    assign Dout = (Dir < 32'd128) ? mem[Dir[6:0]] : 32'd0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
        end else if (MemWrite && Dir < 32'd128) begin
            mem[Dir[6:0]] <= Din;
        end
    end

    always @(negedge clk) if (MemRead || MemWrite) strobe_cnt <= strobe_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase counts cycles since the grant: 0 = free, 1 = access cycle,
    // 2 = completion cycle.
    int          m_phase;
    logic        m_last, m_owner, m_id, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata [2];
    logic [31:0] ref_mem [128];
    logic        m_pick;
    logic        m_inr;

    assign m_pick = (req_q == 2'b11) ? ~m_last : req_q[1];
    assign m_inr  = (m_addr < 32'd128);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase    <= 0;
            m_last     <= 1'b1;
            m_owner    <= 1'b0;
            m_id       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= 32'd0;
            m_wdata    <= 32'd0;
            m_rdata[0] <= 32'd0;
            m_rdata[1] <= 32'd0;
            for (int i = 0; i < 128; i++) ref_mem[i] <= init_word(i);
        end else begin
            case (m_phase)
                0: if (req_q != 2'b00) begin
                    m_id    <= m_pick;
                    m_owner <= m_pick;
                    m_we    <= we_q[m_pick];
                    m_addr  <= addr_q[m_pick];
                    m_wdata <= wdata_q[m_pick];
                    m_phase <= 1;
                end
                1: begin
                    m_phase <= 2;
                    if (m_inr && m_we) ref_mem[m_addr[6:0]] <= m_wdata;
                    m_rdata[m_id] <= (m_inr && !m_we) ? ref_mem[m_addr[6:0]] : 32'd0;
                end
                default: begin
                    m_last  <= m_id;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("owner", 32'(owner), 32'(m_owner));
            chk("memwrite", 32'(MemWrite), 32'(m_phase == 1 && m_we && m_inr));
            chk("memread", 32'(MemRead), 32'(m_phase == 1 && !m_we && m_inr));
            chk("dir", Dir, m_addr);
            chk("din", Din, m_wdata);
            chk("r0_ack", 32'(r0_ack), 32'(m_phase == 2 && m_id == 1'b0));
            chk("r1_ack", 32'(r1_ack), 32'(m_phase == 2 && m_id == 1'b1));
            chk("r0_err", 32'(r0_err), 32'(m_phase == 2 && m_id == 1'b0 && !m_inr));
            chk("r1_err", 32'(r1_err), 32'(m_phase == 2 && m_id == 1'b1 && !m_inr));
            chk("r0_rdata", r0_rdata, m_rdata[0]);
            chk("r1_rdata", r1_rdata, m_rdata[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ack(input int p, output logic [31:0] rd, output logic er);
        logic got;
        got = 1'b0;
        rd = 32'd0;
        er = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? r0_ack : r1_ack) begin
                got = 1'b1;
                rd = (p == 0) ? r0_rdata : r1_rdata;
                er = (p == 0) ? r0_err : r1_err;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic er);
        @(posedge clk); #1;
        req_q[p] = 1'b1;
        we_q[p] = we;
        addr_q[p] = a;
        wdata_q[p] = d;
        wait_ack(p, rd, er);
        @(posedge clk); #1;
        req_q[p] = 1'b0;
    endtask

    task automatic new_op(input int p);
        we_q[p] = 1'($urandom % 2);
        if ($urandom % 8 == 0) addr_q[p] = 32'(128 + $urandom % 300);
        else addr_q[p] = 32'($urandom % 12);
        wdata_q[p] = $urandom;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          s0;
        int          order [$];
        logic [1:0]  ak;
        bit          seen;

        addr_q[0] = 32'd0;
        addr_q[1] = 32'd0;
        wdata_q[0] = 32'd0;
        wdata_q[1] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_dir", Dir, 32'd0);
        chk("rst_din", Din, 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_acks", 32'({r1_ack, r0_ack}), 32'd0);
        chk("rst_rdata", r0_rdata | r1_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single read of word 1
        s0 = strobe_cnt;
        do_op(0, 1'b0, 32'd1, 32'd0, rd, er);
        chk("t1_rdata", rd, 32'd101);
        chk("t1_err", 32'(er), 32'd0);
        chk("t1_strobe_cycles", 32'(strobe_cnt - s0), 32'd1);

        // r1 writes, r0 reads back
        do_op(1, 1'b1, 32'd20, 32'hDEAD_BEEF, rd, er);
        do_op(0, 1'b0, 32'd20, 32'd0, rd, er);
        chk("t2_rdata", rd, 32'hDEAD_BEEF);

        // both ports reading word 0 continuously
        @(posedge clk); #1;
        we_q = 2'b00;
        addr_q[0] = 32'd0;
        addr_q[1] = 32'd0;
        req_q = 2'b11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (r0_ack) order.push_back(0);
            if (r1_ack) order.push_back(1);
            if (r0_ack) chk("t3_r0_rdata", r0_rdata, 32'd67);
            if (r1_ack) chk("t3_r1_rdata", r1_rdata, 32'd67);
        end
        @(posedge clk); #1;
        req_q = 2'b00;
        chk("t3_ack_count", 32'(order.size()), 32'd4);
        for (int i = 1; i < order.size(); i++)
            chk("t3_alternate", 32'(order[i] != order[i-1]), 32'd1);
        repeat (4) @(posedge clk);

        // out of range read
        s0 = strobe_cnt;
        do_op(0, 1'b0, 32'd200, 32'd0, rd, er);
        chk("t4_err", 32'(er), 32'd1);
        chk("t4_rdata", rd, 32'd0);
        chk("t4_no_strobe", 32'(strobe_cnt - s0), 32'd0);

        // address changes after the grant are ignored
        @(posedge clk); #1;
        req_q[1] = 1'b1;
        we_q[1] = 1'b0;
        addr_q[1] = 32'd5;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = MemRead;
        end
        chk("t5_access_seen", 32'(seen), 32'd1);
        addr_q[1] = 32'd9;
        wait_ack(1, rd, er);
        chk("t5_dir", Dir, 32'd5);
        chk("t5_rdata", rd, init_word(5));
        @(posedge clk); #1;
        req_q[1] = 1'b0;

        // reset during a write access
        @(posedge clk); #1;
        req_q[1] = 1'b1;
        we_q[1] = 1'b1;
        addr_q[1] = 32'd30;
        wdata_q[1] = 32'h1234_5678;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = MemWrite;
        end
        chk("t6_write_seen", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_memwrite_drop", 32'(MemWrite), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        req_q = 2'b00;
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_ack", 32'({r1_ack, r0_ack}), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        we_q = 2'b00;
        addr_q[0] = 32'd2;
        addr_q[1] = 32'd3;
        req_q = 2'b11;
        wait_ack(0, rd, er);
        chk("t6_r0_first", 32'(r1_ack), 32'd0);
        chk("t6_r0_rdata", rd, init_word(2));
        @(posedge clk); #1;
        req_q[0] = 1'b0;
        wait_ack(1, rd, er);
        chk("t6_r1_rdata", rd, init_word(3));
        @(posedge clk); #1;
        req_q[1] = 1'b0;

        // randomized traffic on both ports
        ak = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ak = {r1_ack, r0_ack};
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (req_q[p] && ak[p]) begin
                    if ($urandom % 2 == 0) new_op(p);
                    else req_q[p] = 1'b0;
                end else if (!req_q[p]) begin
                    if ($urandom % 3 == 0) begin
                        new_op(p);
                        req_q[p] = 1'b1;
                    end
                end else if ($urandom % 8 == 0) begin
                    new_op(p);
                end
            end
        end
        req_q = 2'b00;
        repeat (6) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
